// File: rtl/rf_wb_scheduler_if.sv
// rtl/rf_wb_scheduler_if.sv - bus bundle between the core pipeline and the write-port scheduler
interface rf_wb_scheduler_if #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            alu_wb_valid;
    logic [4:0]      alu_wb_rd;
    logic [XLEN-1:0] alu_wb_data;
    logic            alu_wb_ready;

    logic            ld_ret_valid;
    logic [4:0]      ld_ret_rd;
    logic [XLEN-1:0] ld_ret_data;
    logic            ld_ret_ready;

    logic            ld_issue_valid;
    logic [4:0]      ld_issue_rd;

    logic            dec_valid;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [4:0]      dec_rd;
    logic            dec_stall;

    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_writedata;
    logic            rf_reg_write;

    logic [31:0]     pending;
    logic [CW-1:0]   fifo_count;

    modport master (
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output ld_ret_valid, ld_ret_rd, ld_ret_data,
        output ld_issue_valid, ld_issue_rd,
        output dec_valid, dec_rs1, dec_rs2, dec_rd,
        input  alu_wb_ready, ld_ret_ready, dec_stall,
        input  rf_rd, rf_writedata, rf_reg_write, pending, fifo_count
    );

    modport slave (
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  ld_ret_valid, ld_ret_rd, ld_ret_data,
        input  ld_issue_valid, ld_issue_rd,
        input  dec_valid, dec_rs1, dec_rs2, dec_rd,
        output alu_wb_ready, ld_ret_ready, dec_stall,
        output rf_rd, rf_writedata, rf_reg_write, pending, fifo_count
    );
endinterface

// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - register file write-port arbiter, load-return FIFO and load scoreboard
module rf_wb_scheduler #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    rf_wb_scheduler_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]      mem_rd   [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_q;
    logic [31:0]     pend_q, pend_d;

    logic full, empty, pop, push;
    logic [4:0] head_rd;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head_rd = mem_rd[rd_ptr];

    // Arbitration: ALU has priority unless the FIFO is full, in which case the head steals the port.
    always_comb begin
        pop              = 1'b0;
        push             = 1'b0;
        bus.alu_wb_ready = 1'b0;
        bus.ld_ret_ready = 1'b0;
        bus.rf_rd        = '0;
        bus.rf_writedata = '0;
        bus.rf_reg_write = 1'b0;
        bus.dec_stall    = 1'b0;
        if (!reset) begin
            if (bus.alu_wb_valid && !full) begin
                bus.alu_wb_ready = 1'b1;
                bus.rf_rd        = bus.alu_wb_rd;
                bus.rf_writedata = bus.alu_wb_data;
            end else if (!empty) begin
                pop              = 1'b1;
                bus.alu_wb_ready = !bus.alu_wb_valid;
                bus.rf_rd        = head_rd;
                bus.rf_writedata = mem_data[rd_ptr];
            end else begin
                bus.alu_wb_ready = 1'b1;
            end
            bus.rf_reg_write = (bus.alu_wb_ready && bus.alu_wb_valid || pop) && (bus.rf_rd != 5'd0);
            bus.ld_ret_ready = !full || pop;
            // rd=0 returns are accepted but dropped: nothing will ever wait on x0.
            push = bus.ld_ret_valid && bus.ld_ret_ready && (bus.ld_ret_rd != 5'd0);
            bus.dec_stall = bus.dec_valid &&
                            ((bus.dec_rs1 != 5'd0 && pend_q[bus.dec_rs1]) ||
                             (bus.dec_rs2 != 5'd0 && pend_q[bus.dec_rs2]) ||
                             (bus.dec_rd  != 5'd0 && pend_q[bus.dec_rd]));
        end
    end

    // Scoreboard next state: a pop clears its rd, a new issue to the same rd takes precedence.
    always_comb begin
        pend_d = pend_q;
        if (pop)
            pend_d[head_rd] = 1'b0;
        if (bus.ld_issue_valid && bus.ld_issue_rd != 5'd0)
            pend_d[bus.ld_issue_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    // FIFO pointers, occupancy and scoreboard registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            pend_q  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
            pend_q  <= pend_d;
        end
    end

    // FIFO storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]   <= bus.ld_ret_rd;
            mem_data[wr_ptr] <= bus.ld_ret_data;
        end
    end

    assign bus.pending    = pend_q;
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb/tb_rf_wb_scheduler.sv - self-checking bench for rf_wb_scheduler
module tb_rf_wb_scheduler;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rf_wb_scheduler_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
    rf_wb_scheduler #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t      q[$];
    bit [31:0] pend;
    int        n_pass  = 0;
    int        n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit busy(input logic [4:0] r);
        return (r != 5'd0) && pend[r];
    endfunction

    // One clock cycle: check every output against the model mid-cycle, then advance the model.
    task automatic cycle();
        bit full, pop, alu_win, push, ar, lr, st, iss;
        logic [4:0] wrd, ird;
        logic [XLEN-1:0] wd;
        ent_t h;
        #4;
        full = (q.size() == DEPTH);
        pop = 0; alu_win = 0; push = 0; ar = 0; lr = 0; st = 0;
        wrd = 0; wd = 0; h = '0;
        if (!reset) begin
            if (bus.alu_wb_valid && !full) begin
                alu_win = 1; ar = 1; wrd = bus.alu_wb_rd; wd = bus.alu_wb_data;
            end else if (q.size() > 0) begin
                pop = 1; h = q[0]; wrd = h.rd; wd = h.data; ar = !bus.alu_wb_valid;
            end else begin
                ar = 1;
            end
            lr   = !full || pop;
            push = bus.ld_ret_valid && lr && (bus.ld_ret_rd != 5'd0);
            st   = bus.dec_valid && (busy(bus.dec_rs1) || busy(bus.dec_rs2) || busy(bus.dec_rd));
        end
        iss = bus.ld_issue_valid && (bus.ld_issue_rd != 5'd0);
        ird = bus.ld_issue_rd;
        chk("alu_wb_ready", bus.alu_wb_ready, ar);
        chk("ld_ret_ready", bus.ld_ret_ready, lr);
        chk("rf_reg_write", bus.rf_reg_write, (alu_win || pop) && wrd != 5'd0);
        chk("rf_rd", bus.rf_rd, wrd);
        chk("rf_writedata", bus.rf_writedata, wd);
        chk("dec_stall", bus.dec_stall, st);
        chk("pending", bus.pending, pend);
        chk("fifo_count", bus.fifo_count, q.size());
        if (push) q.push_back(ent_t'{bus.ld_ret_rd, bus.ld_ret_data});
        @(posedge clk);
        if (reset) begin
            q.delete();
            pend = '0;
        end else begin
            if (pop) begin
                h = q.pop_front();
                pend[h.rd] = 1'b0;
            end
            if (iss) pend[ird] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        bus.alu_wb_valid = 0; bus.alu_wb_rd = 0; bus.alu_wb_data = 0;
        bus.ld_ret_valid = 0; bus.ld_ret_rd = 0; bus.ld_ret_data = 0;
        bus.ld_issue_valid = 0; bus.ld_issue_rd = 0;
        bus.dec_valid = 0; bus.dec_rs1 = 0; bus.dec_rs2 = 0; bus.dec_rd = 0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        pend  = '0;
        @(posedge clk); #1;
        cycle();
        reset = 1'b0;
        cycle();

        // ALU write lands in the same cycle.
        bus.alu_wb_valid = 1; bus.alu_wb_rd = 5'd5; bus.alu_wb_data = 64'h11;
        #4;
        chk("t1_rf_writedata", bus.rf_writedata, 64'h11);
        chk("t1_rf_rd", bus.rf_rd, 5'd5);
        #1;
        @(posedge clk); #1;
        idle();

        // Load scoreboard stall and release.
        bus.ld_issue_valid = 1; bus.ld_issue_rd = 5'd8;
        cycle();
        bus.ld_issue_valid = 0;
        bus.dec_valid = 1; bus.dec_rs1 = 5'd8;
        cycle();
        bus.ld_ret_valid = 1; bus.ld_ret_rd = 5'd8; bus.ld_ret_data = 64'hABCD;
        cycle();
        bus.ld_ret_valid = 0;
        #4;
        chk("t2_write_rd8", bus.rf_rd, 5'd8);
        chk("t2_stall_in_write_cycle", bus.dec_stall, 1'b1);
        #1;
        @(posedge clk); #1;
        pend[8] = 1'b0;
        q.delete();
        chk("t2_pending8_clear", bus.pending[8], 1'b0);
        cycle();
        idle();

        // Continuous ALU traffic fills the FIFO, then the head steals one cycle per pop.
        bus.alu_wb_valid = 1;
        for (int i = 0; i < 4; i++) begin
            bus.alu_wb_rd = 5'(20 + i); bus.alu_wb_data = 64'($urandom);
            bus.ld_ret_valid = 1; bus.ld_ret_rd = 5'(10 + i); bus.ld_ret_data = 64'h1000 + 64'(i);
            cycle();
        end
        chk("t3_full", bus.fifo_count, 4);
        bus.ld_ret_rd = 5'd14; bus.ld_ret_data = 64'h1004;
        #4;
        chk("t3_alu_stolen", bus.alu_wb_ready, 1'b0);
        chk("t3_head_first", bus.rf_writedata, 64'h1000);
        chk("t3_ready_on_pop", bus.ld_ret_ready, 1'b1);
        #1;
        @(posedge clk); #1;
        void'(q.pop_front());
        q.push_back(ent_t'{5'd14, 64'h1004});
        bus.ld_ret_valid = 0;
        for (int i = 0; i < 3; i++) cycle();
        bus.alu_wb_valid = 0;
        for (int i = 0; i < 6; i++) cycle();

        // Reset mid-drain drops buffered returns.
        bus.alu_wb_valid = 1; bus.alu_wb_rd = 5'd1;
        bus.ld_issue_valid = 1; bus.ld_issue_rd = 5'd9;
        bus.ld_ret_valid = 1; bus.ld_ret_rd = 5'd6;
        cycle();
        bus.ld_issue_valid = 0; bus.ld_ret_rd = 5'd7;
        cycle();
        bus.ld_ret_valid = 0; bus.alu_wb_valid = 0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("t4_count", bus.fifo_count, 0);
        chk("t4_pending", bus.pending, 0);
        cycle();

        // x0 everywhere is inert.
        bus.alu_wb_valid = 1; bus.alu_wb_rd = 0; bus.alu_wb_data = 64'h55;
        bus.ld_ret_valid = 1; bus.ld_ret_rd = 0;
        bus.ld_issue_valid = 1; bus.ld_issue_rd = 0;
        bus.dec_valid = 1; bus.dec_rs1 = 0;
        cycle();
        idle();
        cycle();
        chk("t5_count", bus.fifo_count, 0);
        chk("t5_pending", bus.pending, 0);

        // Same-cycle clear and set of rd 3: set wins.
        bus.ld_issue_valid = 1; bus.ld_issue_rd = 5'd3;
        cycle();
        bus.ld_issue_valid = 0;
        bus.ld_ret_valid = 1; bus.ld_ret_rd = 5'd3; bus.ld_ret_data = 64'h33;
        cycle();
        bus.ld_ret_valid = 0;
        bus.ld_issue_valid = 1; bus.ld_issue_rd = 5'd3;
        cycle();
        idle();
        chk("t6_pending3", bus.pending[3], 1'b1);
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            bus.alu_wb_valid   = ($urandom_range(0, 99) < 60);
            bus.alu_wb_rd      = 5'($urandom);
            bus.alu_wb_data    = {32'($urandom), 32'($urandom)};
            bus.ld_ret_valid   = ($urandom_range(0, 99) < 45);
            bus.ld_ret_rd      = 5'($urandom_range(0, 7));
            bus.ld_ret_data    = {32'($urandom), 32'($urandom)};
            bus.ld_issue_valid = ($urandom_range(0, 99) < 40);
            bus.ld_issue_rd    = 5'($urandom_range(0, 7));
            bus.dec_valid      = ($urandom_range(0, 99) < 70);
            bus.dec_rs1        = 5'($urandom_range(0, 8));
            bus.dec_rs2        = 5'($urandom_range(0, 8));
            bus.dec_rd         = 5'($urandom_range(0, 8));
            cycle();
        end
        reset = 1'b0;
        idle();
        for (int i = 0; i < 6; i++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

Write-port scheduler and load scoreboard for the 64-bit register file of the cached RISC-V core. It shares the register file's single write port between in-order ALU writeback and out-of-order load returns from the data cache. Load returns are buffered in a small FIFO. A per-register pending scoreboard stalls decode while a register awaits a load result. It drives the register file's `rd`, `writedata` and `reg_write` ports directly.

## Interface

**Parameters**
- `XLEN`, default 64: data width.
- `DEPTH`, default 4: load-return FIFO entries; power of two, at least 2.

**Ports**
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `alu_wb_valid`  in  1  ALU writeback request this cycle.
- `alu_wb_rd`  in  5  ALU destination register.
- `alu_wb_data`  in  XLEN  ALU result.
- `alu_wb_ready`  out  1  ALU writeback accepted this cycle.
- `ld_ret_valid`  in  1  cache returning load data.
- `ld_ret_rd`  in  5  load destination register.
- `ld_ret_data`  in  XLEN  load data.
- `ld_ret_ready`  out  1  load return accepted into the FIFO.
- `ld_issue_valid`  in  1  load issued to cache; mark its rd pending.
- `ld_issue_rd`  in  5  destination of the issued load.
- `dec_valid`  in  1  decode holds a valid instruction.
- `dec_rs1`, `dec_rs2`, `dec_rd`  in  5 each  decode operand and destination indices.
- `dec_stall`  out  1  decode must hold.
- `rf_rd`  out  5  register file write index.
- `rf_writedata`  out  XLEN  register file write data.
- `rf_reg_write`  out  1  register file write enable.
- `pending`  out  32  scoreboard bits; bit 0 is always 0.
- `fifo_count`  out  clog2(DEPTH)+1  number of FIFO entries.

## Operation

**Write-port arbitration (combinational, each cycle)**
- If the FIFO is full and `alu_wb_valid` is high:
  - the FIFO head wins the port;
  - `alu_wb_ready` is 0, and the ALU holds its request.
- Else if `alu_wb_valid` is high:
  - the ALU wins the port;
  - `alu_wb_ready` is 1.
- Else if the FIFO is non-empty, the FIFO head wins the port and is popped.
- Otherwise there is no write: `rf_reg_write` is 0, and `rf_rd` and `rf_writedata` are 0.
- `alu_wb_ready` is 1 whenever `alu_wb_valid` is low and reset is low.
- The winner's rd and data drive `rf_rd` and `rf_writedata`.
- `rf_reg_write` is 1 only when there is a winner with a nonzero rd.

**Load-return FIFO**
- Load returns are always buffered. They never reach the port in the cycle they are accepted.
- `ld_ret_ready` = not full, or a pop occurs this cycle.
- Accepted returns with rd = 0 are discarded: no push.
- A simultaneous push and pop leaves the count unchanged. Order is strict FIFO.

**Scoreboard**
- `ld_issue_valid` with a nonzero rd sets `pending[rd]` at the edge. rd = 0 is ignored.
- `pending[rd]` clears at the edge where a FIFO pop writes that rd.
- If a set and a clear target the same rd in the same cycle, the set wins.
- ALU writebacks never touch the scoreboard.
- `dec_stall` = `dec_valid` and (`pending[rs1]` or `pending[rs2]` or `pending[rd]`), considering only nonzero indices.

**Reset**
- While `reset` is high, these outputs are forced to 0: `alu_wb_ready`, `ld_ret_ready`, `rf_reg_write`, `dec_stall`.
- At the reset edge, the FIFO is emptied and all pending bits are cleared.
- A reset mid-drain drops buffered returns, with no write.

## Timing

- ALU writeback: 0-cycle latency. The register is written at the edge where `alu_wb_valid` and `alu_wb_ready` are both high.
- Load return accepted at edge N, FIFO previously empty, ALU idle:
  - `rf_reg_write` is high in cycle N+1;
  - the register is written at edge N+1;
  - the pending bit is clear from cycle N+2.
- Decode reading in the write cycle still sees pending = 1 and stalls. This avoids the register file's read-before-write.
- Pending set by `ld_issue` at edge N is visible to `dec_stall` from cycle N+1.
- Maximum FIFO wait under continuous ALU traffic: the FIFO steals the port only once full, so it steals one ALU cycle per pop.
- After reset deasserts, all outputs are 0 except `alu_wb_ready`, which is 1 when `alu_wb_valid` is 0. `fifo_count` and `pending` are 0.

## Test plan

1. Reset, then an ALU write with rd=5, data=0x11 in cycle 1 → `rf_reg_write`=1, `rf_rd`=5, `rf_writedata`=0x11, `alu_wb_ready`=1, all in the same cycle.
2. `ld_issue` rd=8, then `dec_valid` with rs1=8 → `dec_stall`=1. A load return (rd=8, data=0xABCD) is accepted with the ALU idle; next cycle rd 8 is written and `dec_stall` is still 1; the following cycle `pending[8]`=0 and `dec_stall`=0.
3. Continuous `alu_wb_valid` with 4 load returns (DEPTH=4) → `fifo_count` reaches 4. The next cycle has `alu_wb_ready`=0 and the head is written. `ld_ret_ready` stays 1 on pop-plus-push. Order is preserved.
4. FIFO holds 2 entries; assert `reset` for one cycle → `fifo_count`=0, `pending`=0, and no `rf_reg_write` during or after reset.
5. Load return and ALU write with rd=0 → `rf_reg_write`=0, no FIFO push. `ld_issue` rd=0 → `pending`=0. Decode with rs1=0 → no stall.
6. In the same cycle, a FIFO pop writes rd=3 and `ld_issue` marks rd=3 → `pending[3]` stays 1.
